// File: rtl/jcs_pkg.sv
// Shared types and ASCII constants for the JRAM scan reader.
// Holds the FSM state encoding used by jram_reader.
package jcs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    READ  = 2'd2,
    SHOW  = 2'd3
  } state_e;

  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_ZERO = 8'h30;
  localparam logic [7:0] CH_A    = 8'h61;

  localparam logic [31:0] WORD_RST = {4{CH_DASH}};

endpackage

// File: rtl/jram_reader_hex_ascii.sv
// Nibble to lowercase ASCII hex character.
// Purely combinational.
module hex_ascii
  import jcs_pkg::*;
(
  input  logic [3:0] nib,
  output logic [7:0] chr
);

  always_comb begin
    chr = CH_ZERO + {4'h0, nib};
    if (nib > 4'd9) begin
      chr = CH_A + {4'h0, nib} - 8'd10;
    end
  end

endmodule

// File: rtl/jram_reader.sv
// Scans RAM addresses LO..HI, showing "aadd" for each byte read.
// Optional running checksum: define JRAM_READER_CSUM_EN.
module jram_reader
  import jcs_pkg::*;
#(
  parameter int DWELL      = 100000000,
  parameter int ENA_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        START,
  input  logic        STOP,
  input  logic [7:0]  LO,
  input  logic [7:0]  HI,
  input  logic [7:0]  RDATA,
  output logic [7:0]  ADDR,
  output logic        RAM_ENA,
  output logic        RAM_SET,
  output logic [7:0]  DATA,
  output logic [31:0] WORD,
  output logic        BUSY,
  output logic        DONE,
  output logic [7:0]  CSUM
);

  localparam int DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int EN_W = (ENA_CYCLES > 1) ? $clog2(ENA_CYCLES) : 1;
  localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
  localparam logic [EN_W-1:0] EN_LAST = EN_W'(ENA_CYCLES - 1);

  state_e           state_q, state_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       hi_q, hi_d;
  logic [7:0]       data_q, data_d;
  logic [31:0]      word_q, word_d;
  logic             done_q, done_d;
  logic [DW_W-1:0]  dcnt_q, dcnt_d;
  logic [EN_W-1:0]  ecnt_q, ecnt_d;

  logic [7:0] ch_ah, ch_al, ch_dh, ch_dl;

  hex_ascii u_hex_ah (.nib(addr_q[7:4]), .chr(ch_ah));
  hex_ascii u_hex_al (.nib(addr_q[3:0]), .chr(ch_al));
  hex_ascii u_hex_dh (.nib(RDATA[7:4]),  .chr(ch_dh));
  hex_ascii u_hex_dl (.nib(RDATA[3:0]),  .chr(ch_dl));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    hi_d    = hi_q;
    data_d  = data_q;
    word_d  = word_q;
    done_d  = 1'b0;
    dcnt_d  = dcnt_q;
    ecnt_d  = ecnt_q;
    unique case (state_q)
      IDLE: begin
        if (START && !STOP) begin
          hi_d    = HI;
          addr_d  = LO;
          state_d = SETUP;
        end
      end
      SETUP: begin
        ecnt_d  = '0;
        state_d = READ;
      end
      READ: begin
        if (ecnt_q == EN_LAST) begin
          data_d  = RDATA;
          word_d  = {ch_ah, ch_al, ch_dh, ch_dl};
          dcnt_d  = '0;
          state_d = SHOW;
        end else begin
          ecnt_d = ecnt_q + EN_W'(1);
        end
      end
      SHOW: begin
        if (dcnt_q == DW_LAST) begin
          if (addr_q == hi_q) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            addr_d  = addr_q + 8'd1;
            state_d = SETUP;
          end
        end else begin
          dcnt_d = dcnt_q + DW_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Abort wins over any capture or completion in the same cycle
    if (STOP && state_q != IDLE) begin
      state_d = IDLE;
      addr_d  = addr_q;
      data_d  = data_q;
      word_d  = word_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      addr_q  <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      word_q  <= WORD_RST;
      done_q  <= 1'b0;
      dcnt_q  <= '0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      word_q  <= word_d;
      done_q  <= done_d;
      dcnt_q  <= dcnt_d;
      ecnt_q  <= ecnt_d;
    end
  end

`ifdef JRAM_READER_CSUM_EN
  logic [7:0] csum_q, csum_d;
  logic       start_ok, capture;

  assign start_ok = (state_q == IDLE) && START && !STOP;
  assign capture  = (state_q == READ) && (ecnt_q == EN_LAST) && !STOP;

  always_comb begin
    csum_d = csum_q;
    if (start_ok) begin
      csum_d = '0;
    end else if (capture) begin
      csum_d = csum_q + RDATA;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign CSUM = csum_q;
`else
  assign CSUM = 8'h00;
`endif

  assign ADDR    = addr_q;
  assign RAM_ENA = (state_q == READ);
  assign RAM_SET = 1'b0;
  assign DATA    = data_q;
  assign WORD    = word_q;
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;

endmodule

// File: tb/tb_jram_reader.sv
// Self-checking bench for jram_reader with DWELL=4, ENA_CYCLES=2.
// Expected timing and words come from a scan-level model of the block.
module tb_jram_reader;

  localparam int DW = 4;
  localparam int EN = 2;

  logic        CLK, RSTN, START, STOP;
  logic [7:0]  LO, HI, RDATA, ADDR, DATA, CSUM;
  logic        RAM_ENA, RAM_SET, BUSY, DONE;
  logic [31:0] WORD;

  logic [7:0] mem [256];

  int checks   = 0;
  int failures = 0;

  assign RDATA = mem[ADDR];

  jram_reader #(.DWELL(DW), .ENA_CYCLES(EN)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .STOP(STOP),
    .LO(LO), .HI(HI), .RDATA(RDATA), .ADDR(ADDR),
    .RAM_ENA(RAM_ENA), .RAM_SET(RAM_SET), .DATA(DATA),
    .WORD(WORD), .BUSY(BUSY), .DONE(DONE), .CSUM(CSUM)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hx(input logic [3:0] v);
    string s;
    s = "0123456789abcdef";
    return s[int'(v)];
  endfunction

  function automatic logic [31:0] exp_word(input logic [7:0] a,
                                           input logic [7:0] d);
    return {hx(a[7:4]), hx(a[3:0]), hx(d[7:4]), hx(d[3:0])};
  endfunction

  task automatic chk_csum(input string name, input logic [7:0] sum);
`ifdef JRAM_READER_CSUM_EN
    chk(name, CSUM, sum);
`else
    chk(name, CSUM, 8'h00);
`endif
  endtask

  // Full scan: SETUP(1) + READ(EN) + SHOW(DW) per address, DONE after.
  task automatic do_scan(input logic [7:0] lo, input logic [7:0] hi,
                         input bit disturb, output int n);
    logic [7:0] a, d, sum;
    LO = lo;
    HI = hi;
    START = 1'b1;
    tick();
    START = 1'b0;
    LO = 8'($urandom);
    HI = 8'($urandom);
    a = lo;
    sum = 8'h00;
    n = 0;
    while (n < 256) begin
      n++;
      chk("setup_ena", RAM_ENA, 0);
      chk("setup_busy", BUSY, 1);
      chk("setup_addr", ADDR, a);
      chk("ram_set", RAM_SET, 0);
      tick();
      for (int e = 0; e < EN; e++) begin
        chk("read_ena", RAM_ENA, 1);
        chk("read_addr", ADDR, a);
        tick();
      end
      d = mem[a];
      sum = sum + d;
      chk("word", WORD, exp_word(a, d));
      chk("data", DATA, d);
      chk_csum("csum_run", sum);
      for (int k = 0; k < DW; k++) begin
        chk("show_ena", RAM_ENA, 0);
        chk("show_done", DONE, 0);
        chk("ram_set", RAM_SET, 0);
        if (disturb && k == 1) begin
          START = 1'b1;
          LO = 8'($urandom);
          HI = 8'($urandom);
        end
        tick();
        START = 1'b0;
      end
      if (a == hi) break;
      a = a + 8'd1;
    end
    chk("done_pulse", DONE, 1);
    chk("done_busy", BUSY, 0);
    chk_csum("csum_end", sum);
    tick();
    chk("done_len", DONE, 0);
    chk("idle_busy", BUSY, 0);
  endtask

  typedef struct {
    logic [7:0] lo;
    logic [7:0] hi;
    int         exp_n;
    bit         disturb;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int n;
    logic [7:0] lo, len;

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    mem[8'h10] = 8'hAB;
    mem[8'h11] = 8'hCD;
    mem[8'h12] = 8'hEF;
    mem[8'h33] = 8'h05;

    vecs[0] = '{8'h10, 8'h12, 3, 1'b0};
    vecs[1] = '{8'hFE, 8'h01, 4, 1'b1};
    vecs[2] = '{8'h33, 8'h33, 1, 1'b0};
    vecs[3] = '{8'hFF, 8'h00, 2, 1'b1};

    RSTN = 1'b0;
    START = 1'b0;
    STOP = 1'b0;
    LO = 8'h00;
    HI = 8'h00;
    tick();
    tick();
    chk("rst_addr", ADDR, 0);
    chk("rst_word", WORD, 32'h2D2D2D2D);
    chk("rst_busy", BUSY, 0);
    chk("rst_ena", RAM_ENA, 0);
    chk("rst_data", DATA, 0);
    chk("rst_csum", CSUM, 0);
    RSTN = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) begin
      do_scan(vecs[i].lo, vecs[i].hi, vecs[i].disturb, n);
      chk("scan_len", n, vecs[i].exp_n);
    end

    // START and STOP together in IDLE
    START = 1'b1;
    STOP = 1'b1;
    LO = 8'h40;
    tick();
    START = 1'b0;
    STOP = 1'b0;
    chk("ss_busy", BUSY, 0);
    tick();
    chk("ss_busy2", BUSY, 0);

    // STOP during READ of address 0x11
    LO = 8'h10;
    HI = 8'h12;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (1 + EN + DW) tick();
    chk("stop_pre_addr", ADDR, 8'h11);
    tick();
    chk("stop_in_read", RAM_ENA, 1);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("stop_busy", BUSY, 0);
    chk("stop_ena", RAM_ENA, 0);
    chk("stop_word", WORD, 32'h31306162);
    chk("stop_addr", ADDR, 8'h11);
    chk("stop_data", DATA, 8'hAB);
    chk("stop_done", DONE, 0);
    repeat (3) begin
      tick();
      chk("stop_nodone", DONE, 0);
      chk("stop_idle", BUSY, 0);
    end

    // Asynchronous reset during SHOW
    LO = 8'h33;
    HI = 8'h33;
    START = 1'b1;
    tick();
    START = 1'b0;
    repeat (1 + EN) tick();
    chk("pre_rst_word", WORD, 32'h33333035);
    RSTN = 1'b0;
    #1;
    chk("arst_word", WORD, 32'h2D2D2D2D);
    chk("arst_addr", ADDR, 0);
    chk("arst_busy", BUSY, 0);
    chk("arst_data", DATA, 0);
    chk("arst_ena", RAM_ENA, 0);
    chk("arst_done", DONE, 0);
    chk("arst_csum", CSUM, 0);
    tick();
    RSTN = 1'b1;
    tick();
    chk("post_rst_busy", BUSY, 0);

    // Randomized short scans
    for (int i = 0; i < 8; i++) begin
      lo = 8'($urandom);
      len = 8'($urandom_range(0, 3));
      for (int j = 0; j <= int'(len); j++) mem[8'(lo + j)] = 8'($urandom);
      do_scan(lo, lo + len, 1'($urandom), n);
      chk("rnd_len", n, int'(len) + 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jram_reader.md
JRAM_READER -- requirements
Module: jram_reader

Interface
REQ-001 SHALL have parameter DWELL, default 100000000, display cycles per address (>=1).
REQ-002 SHALL have parameter ENA_CYCLES, default 2, cycles RAM_ENA is held per read (>=1).
REQ-003 SHALL have port CLK  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port START  input  1  single-cycle pulse, begins a scan.
REQ-006 SHALL have port STOP  input  1  single-cycle pulse, aborts a scan.
REQ-007 SHALL have port LO  input  8  first address of scan.
REQ-008 SHALL have port HI  input  8  last address of scan.
REQ-009 SHALL have port RDATA  input  8  RAM read data.
REQ-010 SHALL have port ADDR  output  8  RAM address.
REQ-011 SHALL have port RAM_ENA  output  1  RAM output enable.
REQ-012 SHALL have port RAM_SET  output  1  RAM write strobe, constant 0.
REQ-013 SHALL have port DATA  output  8  last captured byte.
REQ-014 SHALL have port WORD  output  32  four ASCII characters for the seven-segment word driver.
REQ-015 SHALL have port BUSY  output  1  high while not IDLE.
REQ-016 SHALL have port DONE  output  1  one-cycle pulse on normal scan completion.
REQ-017 SHALL have port CSUM  output  8  running checksum (see Configuration).

Function
REQ-018 SHALL implement states IDLE, SETUP, READ, SHOW.
REQ-019 IDLE + START (STOP low): latch HI, ADDR<=LO, go SETUP; BUSY high from next cycle.
REQ-020 SETUP SHALL last exactly 1 cycle with RAM_ENA low, then go READ.
REQ-021 READ SHALL hold RAM_ENA high for exactly ENA_CYCLES cycles, with ADDR stable throughout.
REQ-022 On the last READ cycle, DATA<=RDATA and WORD<={hex(ADDR[7:4]),hex(ADDR[3:0]),hex(DATA[7:4]),hex(DATA[3:0])}; state goes SHOW.
REQ-023 Hex characters SHALL be ASCII '0'-'9' and lowercase 'a'-'f'.
REQ-024 SHOW SHALL last exactly DWELL cycles with RAM_ENA low.
REQ-025 At end of SHOW: if ADDR equals latched HI, pulse DONE for 1 cycle and go IDLE; otherwise ADDR<=ADDR+1 modulo 256 and go SETUP.
REQ-026 LO>HI SHALL scan through 0xFF, wrap to 0x00 and continue to HI; LO==HI SHALL read one address.
REQ-027 STOP in any non-IDLE state SHALL force IDLE next cycle: RAM_ENA low, DATA/WORD/ADDR retained, no DONE.
REQ-028 START while BUSY SHALL be ignored; START and STOP in the same IDLE cycle SHALL leave the block in IDLE.
REQ-029 Latency: START at cycle 0 -> SETUP in cycle 1, RAM_ENA in cycles 2..1+ENA_CYCLES, WORD updated at cycle 2+ENA_CYCLES.
REQ-030 Changes to HI during a scan SHALL have no effect.

Reset
REQ-031 RSTN low SHALL immediately force IDLE, ADDR=0, RAM_ENA=0, RAM_SET=0, DATA=0, WORD="----" (32'h2D2D2D2D), BUSY=0, DONE=0, CSUM=0, and clear the dwell and enable counters, including mid-scan.

Configuration
REQ-032 With JRAM_READER_CSUM_EN defined: CSUM clears on an accepted START and adds each captured byte modulo 256 in the capture cycle.
REQ-033 Without JRAM_READER_CSUM_EN: CSUM port SHALL remain present and tied to 0, and no adder logic SHALL be present.

Structure
REQ-034 The state enum and the ASCII constants ('-', '0', 'a') SHALL live in shared package jcs_pkg.
REQ-035 Nibble-to-ASCII conversion SHALL be sub-module hex_ascii (4-bit in, 8-bit out), instantiated 4 times.
REQ-036 The dwell counter width SHALL be derived from DWELL via $clog2.

Verification (DWELL=4, ENA_CYCLES=2)
REQ-037 RAM[0x10..0x12]=AB,CD,EF, LO=10, HI=12, START -> WORD "10ab","11cd","12ef", one DONE pulse, CSUM=0x67 (with macro).
REQ-038 LO=FE, HI=01 -> ADDR sequence FE,FF,00,01 then DONE.
REQ-039 STOP during READ of addr 0x11 -> IDLE next cycle, RAM_ENA 0, WORD still "10ab", no DONE.
REQ-040 RSTN low during SHOW -> all outputs at reset values asynchronously, WORD "----".
REQ-041 Second START while BUSY -> ignored, scan order unchanged; RAM_SET is 0 in every cycle.
REQ-042 LO=HI=0x33, RAM[0x33]=0x05 -> single read, WORD "3305", DONE 1 cycle, CSUM=0x05 (with macro), 0x00 (without).
